seq_detect_param: RTL and testbench

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_detect_param.sv | 73 +++++++
 tb/tb_seq_detect_param.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Serial pattern detector with runtime-loadable pattern, overlap control and a
// saturating match counter. Moore output pulses one cycle after the final bit.
module seq_detect_param #(
   parameter int unsigned     N         = 4,
   parameter logic [N-1:0]    RESET_PAT = N'(4'b1001),
   parameter int unsigned     CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in,
   input  logic             in_valid,
   input  logic             overlap,
   input  logic             pat_load,
   input  logic [N-1:0]     pat_in,
   input  logic             count_clr,
   output logic             out,
   output logic [CNT_W-1:0] match_cnt
);

   localparam int unsigned      FW        = $clog2(N + 1);
   localparam logic [FW-1:0]    FILL_FULL = FW'(N);

   logic [N-1:0]     r_pat;
   logic [N-1:0]     r_hist;
   logic [FW-1:0]    r_fill;
   logic             r_out;
   logic [CNT_W-1:0] r_cnt;

   logic [N-1:0]     w_hist_nx;
   logic [FW-1:0]    w_fill_nx;
   logic             w_match;

   // A load edge never produces a match: the sampled bit is discarded.
   always_comb begin
      w_hist_nx = {r_hist[N-2:0], in};
      w_fill_nx = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + 1'b1;
      w_match   = in_valid && !pat_load &&
                  (w_fill_nx == FILL_FULL) && (w_hist_nx == r_pat);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pat  <= RESET_PAT;
         r_hist <= '0;
         r_fill <= '0;
         r_out  <= 1'b0;
         r_cnt  <= '0;
      end else begin
         r_out <= w_match;

         if (pat_load) begin
            r_pat  <= pat_in;
            r_hist <= '0;
            r_fill <= '0;
         end else if (in_valid) begin
            r_hist <= w_hist_nx;
            if (w_match)
               r_fill <= overlap ? FILL_FULL : '0;
            else
               r_fill <= w_fill_nx;
         end

         if (count_clr)
            r_cnt <= '0;
         else if (w_match && (r_cnt != '1))
            r_cnt <= r_cnt + 1'b1;
      end
   end

   assign out       = r_out;
   assign match_cnt = r_cnt;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed self-checking bench for seq_detect_param (default instance plus a
// CNT_W=2 instance for counter saturation).
module tb_seq_detect_param;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in;
   logic       in_valid;
   logic       overlap;
   logic       pat_load;
   logic [3:0] pat_in;
   logic       count_clr;
   logic       out_a;
   logic [7:0] cnt_a;
   logic       out_b;
   logic [1:0] cnt_b;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   seq_detect_param #(.N(4), .RESET_PAT(4'b1001), .CNT_W(8)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid),
      .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in),
      .count_clr(count_clr), .out(out_a), .match_cnt(cnt_a)
   );

   seq_detect_param #(.N(4), .RESET_PAT(4'b1001), .CNT_W(2)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid),
      .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in),
      .count_clr(count_clr), .out(out_b), .match_cnt(cnt_b)
   );

   // Drive one edge worth of serial input, then sample 1 time unit later.
   task automatic step(input logic b, input logic v);
      in       = b;
      in_valid = v;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(1'b0, 1'b0);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (out_a !== 1'b0) begin
         n_fail++; $display("FAIL reset_out got=%b exp=0", out_a);
      end
      n_checks++;
      if (cnt_a !== 8'd0) begin
         n_fail++; $display("FAIL reset_cnt got=%0d exp=0", cnt_a);
      end
      n_checks++;
      if (cnt_b !== 2'd0) begin
         n_fail++; $display("FAIL reset_cnt_b got=%0d exp=0", cnt_b);
      end
   endtask

   task automatic test_overlap();
      logic [6:0] s = 7'b1001001;
      logic [6:0] e = 7'b0001001;
      do_reset();
      overlap = 1'b1;
      for (int i = 6; i >= 0; i--) begin
         step(s[i], 1'b1);
         n_checks++;
         if (out_a !== e[i]) begin
            n_fail++; $display("FAIL overlap_out bit%0d got=%b exp=%b", 7 - i, out_a, e[i]);
         end
      end
      n_checks++;
      if (cnt_a !== 8'd2) begin
         n_fail++; $display("FAIL overlap_cnt got=%0d exp=2", cnt_a);
      end
   endtask

   task automatic test_non_overlap();
      logic [6:0] s = 7'b1001001;
      logic [6:0] e = 7'b0001000;
      do_reset();
      overlap = 1'b0;
      for (int i = 6; i >= 0; i--) begin
         step(s[i], 1'b1);
         n_checks++;
         if (out_a !== e[i]) begin
            n_fail++; $display("FAIL nonoverlap_out bit%0d got=%b exp=%b", 7 - i, out_a, e[i]);
         end
      end
      n_checks++;
      if (cnt_a !== 8'd1) begin
         n_fail++; $display("FAIL nonoverlap_cnt got=%0d exp=1", cnt_a);
      end
   endtask

   task automatic test_stall();
      do_reset();
      overlap = 1'b1;
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0);
         n_checks++;
         if (out_a !== 1'b0) begin
            n_fail++; $display("FAIL stall_out cycle%0d got=%b exp=0", i, out_a);
         end
      end
      step(1'b0, 1'b1);
      n_checks++;
      if (out_a !== 1'b0) begin
         n_fail++; $display("FAIL stall_bit3 got=%b exp=0", out_a);
      end
      step(1'b1, 1'b1);
      n_checks++;
      if (out_a !== 1'b1) begin
         n_fail++; $display("FAIL stall_bit4 got=%b exp=1", out_a);
      end
      n_checks++;
      if (cnt_a !== 8'd1) begin
         n_fail++; $display("FAIL stall_cnt got=%0d exp=1", cnt_a);
      end
   endtask

   task automatic test_pat_load();
      logic [7:0] s = 8'b0110_1001;
      logic [7:0] e = 8'b0001_0000;
      do_reset();
      overlap = 1'b1;
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      // This bit would complete 1001 if the load did not win.
      pat_load = 1'b1;
      pat_in   = 4'b0110;
      step(1'b1, 1'b1);
      pat_load = 1'b0;
      pat_in   = 4'b0000;
      n_checks++;
      if (out_a !== 1'b0) begin
         n_fail++; $display("FAIL load_edge_out got=%b exp=0", out_a);
      end
      for (int i = 7; i >= 0; i--) begin
         step(s[i], 1'b1);
         n_checks++;
         if (out_a !== e[i]) begin
            n_fail++; $display("FAIL load_out bit%0d got=%b exp=%b", 8 - i, out_a, e[i]);
         end
      end
      n_checks++;
      if (cnt_a !== 8'd1) begin
         n_fail++; $display("FAIL load_cnt got=%0d exp=1", cnt_a);
      end
   endtask

   task automatic test_saturate();
      logic [12:0] s  = 13'b1001001001001;
      logic [12:0] e  = 13'b0001001001001;
      logic [1:0]  ec = 2'd0;
      do_reset();
      overlap = 1'b1;
      for (int i = 12; i >= 0; i--) begin
         step(s[i], 1'b1);
         if (e[i] && ec != 2'd3) ec = ec + 2'd1;
         n_checks++;
         if (out_b !== e[i] || cnt_b !== ec) begin
            n_fail++;
            $display("FAIL sat bit%0d got out=%b cnt=%0d exp out=%b cnt=%0d",
                     13 - i, out_b, cnt_b, e[i], ec);
         end
      end
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      count_clr = 1'b1;
      step(1'b1, 1'b1);
      count_clr = 1'b0;
      n_checks++;
      if (out_b !== 1'b1) begin
         n_fail++; $display("FAIL clr_match_out got=%b exp=1", out_b);
      end
      n_checks++;
      if (cnt_b !== 2'd0) begin
         n_fail++; $display("FAIL clr_match_cnt got=%0d exp=0", cnt_b);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      overlap = 1'b1;
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      n_checks++;
      if (out_a !== 1'b1 || cnt_a !== 8'd1) begin
         n_fail++; $display("FAIL pre_reset got out=%b cnt=%0d exp out=1 cnt=1", out_a, cnt_a);
      end
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      // Valid bit during reset must be ignored.
      rst_n = 1'b0;
      step(1'b1, 1'b1);
      rst_n = 1'b1;
      n_checks++;
      if (out_a !== 1'b0 || cnt_a !== 8'd0) begin
         n_fail++; $display("FAIL mid_reset got out=%b cnt=%0d exp out=0 cnt=0", out_a, cnt_a);
      end
      step(1'b1, 1'b1);
      n_checks++;
      if (out_a !== 1'b0) begin
         n_fail++; $display("FAIL straddle_out got=%b exp=0", out_a);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      in        = 1'b0;
      in_valid  = 1'b0;
      overlap   = 1'b0;
      pat_load  = 1'b0;
      pat_in    = 4'b0000;
      count_clr = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_overlap();
      test_non_overlap();
      test_stall();
      test_pat_load();
      test_saturate();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
